// File: rtl/adc_sample_ctrl_pkg.sv
// Shared FSM encoding and clamp limits for the ADC sample controller.
package adc_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_STROBE = 2'd3;

    localparam int unsigned MIN_PERIOD  = 2;
    localparam int unsigned MIN_TIMEOUT = 1;

    function automatic logic [31:0] clamp_min(input logic [31:0] v, input logic [31:0] lo);
        return (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// Valid/ready result stream carrying averaged samples downstream.
interface adc_sample_ctrl_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adc_sample_ctrl_out_hold.sv
// Single-entry holding register for averaged results with overrun detection.
module adc_out_hold #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic [W-1:0]      avg_data_i,
    input  logic              avg_valid_i,
    adc_sample_ctrl_if.master res,
    output logic              err_overrun_o
);

    logic [W-1:0] data_q, data_d;
    logic         vld_q, vld_d;
    logic         ovr_q, ovr_d;
    logic         room;

    // A slot is free if empty or being drained this very cycle.
    assign room = !vld_q || res.ready;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (vld_q && res.ready) vld_d = 1'b0;
        if (avg_valid_i && room) begin
            data_d = avg_data_i;
            vld_d  = 1'b1;
        end
        ovr_d = (clr_i ? 1'b0 : ovr_q) | (avg_valid_i & ~room);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
        end
    end

    assign res.data      = data_q;
    assign res.valid     = vld_q;
    assign err_overrun_o = ovr_q;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Paced ADC conversion sequencer feeding an external averager, with burst/stop
// control, conversion timeout and a held output result.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int ADC_WIDTH      = 8,
    parameter int LPF_DEPTH_BITS = 4,
    parameter int DIV_WIDTH      = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic [DIV_WIDTH-1:0] timeout,
    input  logic [CNT_WIDTH-1:0] burst_len,
    output logic                 adc_start,
    input  logic                 adc_done,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic [ADC_WIDTH-1:0] avg_raw,
    output logic                 avg_sample,
    input  logic [ADC_WIDTH-1:0] avg_data,
    input  logic                 avg_valid,
    output logic [ADC_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    localparam logic [LPF_DEPTH_BITS:0] SMP_FULL = (LPF_DEPTH_BITS+1)'(1) << LPF_DEPTH_BITS;

    logic [1:0]                st_q, st_d;
    logic [DIV_WIDTH-1:0]      per_q, per_d;
    logic [DIV_WIDTH-1:0]      tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]      res_cnt_q, res_cnt_d;
    logic [LPF_DEPTH_BITS:0]   smp_q, smp_d;
    logic                      stop_pend_q, stop_pend_d;
    logic                      adc_start_q, adc_start_d;
    logic                      avg_sample_q, avg_sample_d;
    logic [ADC_WIDTH-1:0]      avg_raw_q, avg_raw_d;
    logic                      err_tmo_q, err_tmo_d;

    logic [31:0] per_lim, tmo_lim;
    logic        tick, tmo_hit, burst_on, done, last_grp, hold, stop_now, idle_start;

    assign per_lim    = clamp_min(32'(period), MIN_PERIOD) - 32'd1;
    assign tmo_lim    = clamp_min(32'(timeout), MIN_TIMEOUT) - 32'd1;
    assign tick       = 32'(per_q) >= per_lim;
    assign tmo_hit    = 32'(tmo_q) >= tmo_lim;
    assign burst_on   = burst_len != '0;
    assign done       = burst_on && (res_cnt_q >= burst_len);
    assign last_grp   = burst_on && (res_cnt_q == burst_len - CNT_WIDTH'(1));
    // Final group fully sampled: wait for its result instead of taking extra samples.
    assign hold       = last_grp && (smp_q == SMP_FULL);
    assign stop_now   = stop_pend_q | stop;
    assign idle_start = (st_q == ST_IDLE) && start;

    always_comb begin
        st_d         = st_q;
        per_d        = per_q;
        tmo_d        = tmo_q;
        res_cnt_d    = res_cnt_q;
        smp_d        = smp_q;
        stop_pend_d  = stop_pend_q;
        adc_start_d  = 1'b0;
        avg_sample_d = 1'b0;
        avg_raw_d    = avg_raw_q;
        err_tmo_d    = err_tmo_q;

        if (st_q != ST_IDLE) begin
            if (!(&per_q)) per_d = per_q + DIV_WIDTH'(1);
            if (stop) stop_pend_d = 1'b1;
        end
        if (avg_valid && !(&res_cnt_q)) res_cnt_d = res_cnt_q + CNT_WIDTH'(1);
        if (avg_valid)
            smp_d = '0;
        else if (st_q == ST_STROBE && smp_q != SMP_FULL)
            smp_d = smp_q + (LPF_DEPTH_BITS+1)'(1);

        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    st_d      = ST_WAIT;
                    per_d     = '1;
                    res_cnt_d = '0;
                    smp_d     = '0;
                    err_tmo_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    st_d = ST_IDLE;
                end else if (tick && !hold) begin
                    st_d        = ST_CONV;
                    adc_start_d = 1'b1;
                    per_d       = '0;
                    tmo_d       = '0;
                end
            end
            ST_CONV: begin
                if (!(&tmo_q)) tmo_d = tmo_q + DIV_WIDTH'(1);
                if (adc_done) begin
                    avg_raw_d    = adc_data;
                    avg_sample_d = 1'b1;
                    st_d         = ST_STROBE;
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    st_d      = stop_now ? ST_IDLE : ST_WAIT;
                end
            end
            default: begin
                st_d = (stop_now || done) ? ST_IDLE : ST_WAIT;
            end
        endcase

        if (st_q != ST_IDLE && st_d == ST_IDLE) stop_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q         <= ST_IDLE;
            per_q        <= '0;
            tmo_q        <= '0;
            res_cnt_q    <= '0;
            smp_q        <= '0;
            stop_pend_q  <= 1'b0;
            adc_start_q  <= 1'b0;
            avg_sample_q <= 1'b0;
            avg_raw_q    <= '0;
            err_tmo_q    <= 1'b0;
        end else begin
            st_q         <= st_d;
            per_q        <= per_d;
            tmo_q        <= tmo_d;
            res_cnt_q    <= res_cnt_d;
            smp_q        <= smp_d;
            stop_pend_q  <= stop_pend_d;
            adc_start_q  <= adc_start_d;
            avg_sample_q <= avg_sample_d;
            avg_raw_q    <= avg_raw_d;
            err_tmo_q    <= err_tmo_d;
        end
    end

    adc_sample_ctrl_if #(.W(ADC_WIDTH)) res_if ();

    assign res_if.ready = out_ready;
    assign out_data     = res_if.data;
    assign out_valid    = res_if.valid;

    adc_out_hold #(.W(ADC_WIDTH)) u_hold (
        .clk           (clk),
        .rstn          (rstn),
        .clr_i         (idle_start),
        .avg_data_i    (avg_data),
        .avg_valid_i   (avg_valid),
        .res           (res_if.master),
        .err_overrun_o (err_overrun)
    );

    assign adc_start   = adc_start_q;
    assign avg_sample  = avg_sample_q;
    assign avg_raw     = avg_raw_q;
    assign busy        = st_q != ST_IDLE;
    assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench: ADC and averager models driven cycle by cycle, hand-computed expectations.
module tb_adc_sample_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] period = 16'd10, timeout = 16'd20, burst_len = 16'd0;
    logic        adc_start, adc_done = 1'b0;
    logic [7:0]  adc_data = 8'd0;
    logic [7:0]  avg_raw;
    logic        avg_sample;
    logic [7:0]  avg_data = 8'd0;
    logic        avg_valid = 1'b0;
    logic        busy, err_timeout, err_overrun;

    adc_sample_ctrl_if #(.W(8)) res ();

    adc_sample_ctrl #(
        .ADC_WIDTH(8), .LPF_DEPTH_BITS(4), .DIV_WIDTH(16), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .period(period), .timeout(timeout), .burst_len(burst_len),
        .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .avg_raw(avg_raw), .avg_sample(avg_sample),
        .avg_data(avg_data), .avg_valid(avg_valid),
        .out_data(res.data), .out_valid(res.valid), .out_ready(res.ready),
        .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_pass = 0, ncyc = 0;
    int   dn_cnt, k_done, av_sum, av_n;
    logic av_pend, adc_en, prev_done;
    logic [7:0] av_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: sample just after the edge, advance ADC/averager models, drive inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        ncyc++;
        start     = 1'b0;
        stop      = 1'b0;
        prev_done = adc_done;
        adc_done  = 1'b0;
        if (dn_cnt != 0) begin
            dn_cnt--;
            if (dn_cnt == 0) begin
                adc_done = 1'b1;
                adc_data = 8'(5 * k_done + 1);
                k_done++;
            end
        end
        if (adc_start && adc_en) dn_cnt = 3;
        avg_valid = 1'b0;
        if (av_pend) begin
            avg_valid = 1'b1;
            avg_data  = av_val;
            av_pend   = 1'b0;
        end
        if (avg_sample) begin
            av_sum += int'(avg_raw);
            av_n++;
            if (av_n == 16) begin
                av_val  = 8'(av_sum >> 4);
                av_pend = 1'b1;
                av_sum  = 0;
                av_n    = 0;
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; stop = 1'b0; adc_done = 1'b0; avg_valid = 1'b0;
        res.ready = 1'b0;
        dn_cnt = 0; k_done = 0; av_sum = 0; av_n = 0; av_pend = 1'b0; adc_en = 1'b1;
        prev_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts, t0, t1, te, tf, n_st, n_smp, n_res, bad_iv, smp_bad, smp_idle, nb, last_st, first_st;
        logic found;
        logic [7:0] rv [4];

        // Reset state
        do_reset();
        chk("reset_ctl", 32'({busy, adc_start, avg_sample, res.valid, err_timeout, err_overrun}), 32'd0);
        chk("reset_data", 32'({avg_raw, res.data}), 32'd0);

        // Burst of 2 results at period 10, ADC answering 3 cycles after each request
        period = 16'd10; timeout = 16'd20; burst_len = 16'd2; res.ready = 1'b1;
        cyc(); start = 1'b1; ts = ncyc;
        n_st = 0; n_smp = 0; n_res = 0; bad_iv = 0; smp_bad = 0; last_st = 0; first_st = 0;
        for (int i = 0; i < 800; i++) begin
            cyc();
            if (adc_start) begin
                if (n_st == 0) first_st = ncyc;
                else if (ncyc - last_st != 10) bad_iv++;
                last_st = ncyc;
                n_st++;
            end
            if (avg_sample) begin
                if (!prev_done || avg_raw !== 8'(5 * n_smp + 1)) smp_bad++;
                n_smp++;
            end
            if (res.valid && res.ready) begin
                if (n_res < 4) rv[n_res] = res.data;
                n_res++;
            end
            if (i > 2 && !busy) break;
        end
        chk("burst_first_lat", 32'(first_st - ts), 32'd2);
        chk("burst_nstart", 32'(n_st), 32'd32);
        chk("burst_interval", 32'(bad_iv), 32'd0);
        chk("burst_nsample", 32'(n_smp), 32'd32);
        chk("burst_raw_vs_strobe", 32'(smp_bad), 32'd0);
        chk("burst_nresult", 32'(n_res), 32'd2);
        chk("burst_res0", 32'(rv[0]), 32'd38);
        chk("burst_res1", 32'(rv[1]), 32'd118);
        chk("burst_idle", 32'({busy, err_timeout, err_overrun}), 32'd0);

        // Conversion timeout with the ADC silent
        do_reset();
        adc_en = 1'b0; period = 16'd10; timeout = 16'd5; burst_len = 16'd0; res.ready = 1'b1;
        cyc(); start = 1'b1;
        t0 = -1; t1 = -1; te = -1; n_smp = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (adc_start) begin
                if (t0 < 0) t0 = ncyc;
                else if (t1 < 0) t1 = ncyc;
            end
            if (err_timeout && te < 0) te = ncyc;
            if (avg_sample) n_smp++;
        end
        chk("tmo_err_delay", 32'(te - t0), 32'd5);
        chk("tmo_next_start", 32'(t1 - t0), 32'd10);
        chk("tmo_no_sample", 32'(n_smp), 32'd0);
        stop = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!busy) begin found = 1'b1; break; end
        end
        chk("tmo_stop_idle", 32'(found), 32'd1);
        chk("tmo_err_sticky", 32'(err_timeout), 32'd1);
        cyc(); start = 1'b1;
        cyc();
        chk("tmo_err_clear", 32'(err_timeout), 32'd0);

        // Output holding register and overrun
        do_reset();
        res.ready = 1'b0;
        cyc(); avg_valid = 1'b1; avg_data = 8'h5A;
        cyc();
        chk("hold_cap", 32'({res.valid, res.data, err_overrun}), 32'({1'b1, 8'h5A, 1'b0}));
        avg_valid = 1'b1; avg_data = 8'hC3;
        cyc();
        chk("hold_drop_data", 32'({res.valid, res.data}), 32'({1'b1, 8'h5A}));
        chk("hold_overrun", 32'(err_overrun), 32'd1);
        res.ready = 1'b1; avg_valid = 1'b1; avg_data = 8'h77;
        cyc();
        chk("hold_accept_cap", 32'({res.valid, res.data, err_overrun}), 32'({1'b1, 8'h77, 1'b1}));
        cyc();
        chk("hold_drain", 32'({res.valid, res.data}), 32'({1'b0, 8'h77}));
        start = 1'b1;
        cyc();
        chk("hold_ovr_clear", 32'(err_overrun), 32'd0);

        // Stop during a conversion: one last sample then idle
        do_reset();
        period = 16'd10; timeout = 16'd20; burst_len = 16'd0; res.ready = 1'b1;
        cyc(); start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (adc_start) begin found = 1'b1; break; end
        end
        chk("stop_first_start", 32'(found), 32'd1);
        t0 = ncyc; stop = 1'b1;
        n_smp = 0; n_st = 0; smp_idle = 0; tf = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (avg_sample) begin
                n_smp++;
                if (!busy) smp_idle++;
            end
            if (adc_start) n_st++;
            if (!busy && tf < 0) tf = ncyc;
        end
        chk("stop_one_sample", 32'(n_smp), 32'd1);
        chk("stop_no_restart", 32'(n_st), 32'd0);
        chk("stop_idle_time", 32'(tf - t0), 32'd5);
        chk("stop_sample_busy", 32'(smp_idle), 32'd0);
        chk("stop_busy_low", 32'(busy), 32'd0);

        // Asynchronous reset during a conversion
        do_reset();
        period = 16'd10; timeout = 16'd20; burst_len = 16'd0;
        cyc(); start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (avg_sample) begin found = 1'b1; break; end
        end
        chk("rst_pre_raw", 32'({found, avg_raw}), 32'({1'b1, 8'd1}));
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (adc_start) begin found = 1'b1; break; end
        end
        chk("rst_pre_start", 32'(found), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_async_ctl", 32'({busy, adc_start, avg_sample, res.valid, err_timeout, err_overrun}), 32'd0);
        chk("rst_async_raw", 32'(avg_raw), 32'd0);
        cyc(); cyc();
        rstn = 1'b1;
        n_smp = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (avg_sample) n_smp++;
            if (busy) nb++;
        end
        chk("rst_late_done", 32'({n_smp[7:0], nb[7:0], avg_raw}), 32'd0);
        cyc(); start = 1'b1; ts = ncyc;
        t0 = -1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (adc_start && t0 < 0) t0 = ncyc;
            if (avg_sample) begin found = 1'b1; break; end
        end
        chk("rst_restart_lat", 32'(t0 - ts), 32'd2);
        chk("rst_restart_raw", 32'({found, avg_raw}), 32'({1'b1, 8'd11}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
